// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle core control path: opcodes,
// controller states, datapath mux select encodings and the bundle of
// control lines produced by the state decoder.
package core_ctrl_pkg;

   // Instruction opcodes (IR[31:26]); anything else is illegal
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Register write-back select (10/11 reserved)
   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;

   // PC source select
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // ALU operation select
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_FUNCT = 4'b0010;

   typedef enum logic [3:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_LW_WB,
      S_EXEC_R,
      S_R_WB,
      S_EXEC_I,
      S_I_WB,
      S_BRANCH,
      S_JUMP,
      S_FAULT
   } state_t;

   // Every control line the controller drives, as one bundle
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       reg_dst;
      logic [1:0] wb_sel;
      logic [1:0] pc_src;
      logic       instr_done;
      logic       fault;
   } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational decode of the controller state into datapath
// control lines. mem_ready gates the FETCH write enables and the MEM_WR
// retire; alu_zero decides whether a branch writes the PC.
module ctrl_decode
   import core_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   alu_zero,
   output ctrl_t  ctrl
);

   // Everything defaults to 0; each state raises only the lines it needs
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR, S_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         S_LW_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.wb_sel     = WB_MEM;
            ctrl.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_req    = 1'b1;
            ctrl.mem_we     = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.wb_sel     = WB_ALUOUT;
            ctrl.instr_done = 1'b1;
         end
         S_I_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.wb_sel     = WB_ALUOUT;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_REG;
            ctrl.alu_op     = ALU_SUB;
            ctrl.pc_src     = PC_ALUOUT;
            ctrl.pc_write   = alu_zero;
            ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_src     = PC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         S_FAULT: begin
            ctrl.fault = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences the shared datapath through
// fetch/decode/execute/write-back, counts retired instructions and
// parks in FAULT on an illegal opcode until reset.
module multicycle_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          opcode,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [3:0]          alu_op,
   output logic                reg_dst,
   output logic [1:0]          wb_sel,
   output logic [1:0]          pc_src,
   output logic                instr_done,
   output logic [RETIRE_W-1:0] retired,
   output logic                fault
);

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;

   ctrl_decode u_decode (
      .state     (state),
      .mem_ready (mem_ready),
      .alu_zero  (alu_zero),
      .ctrl      (ctrl)
   );

   assign mem_req    = ctrl.mem_req;
   assign mem_we     = ctrl.mem_we;
   assign iord       = ctrl.iord;
   assign ir_write   = ctrl.ir_write;
   assign pc_write   = ctrl.pc_write;
   assign reg_write  = ctrl.reg_write;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign reg_dst    = ctrl.reg_dst;
   assign wb_sel     = ctrl.wb_sel;
   assign pc_src     = ctrl.pc_src;
   assign instr_done = ctrl.instr_done;
   assign fault      = ctrl.fault;

   // State register; reset forces RESET so every output drops at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RESET;
      end else begin
         state <= state_next;
      end
   end

   // Next-state sequencing; memory states hold until mem_ready
   always_comb begin
      state_next = state;
      case (state)
         S_RESET:    state_next = S_FETCH;
         S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEM_ADDR;
               OP_RTYPE:     state_next = S_EXEC_R;
               OP_ADDI:      state_next = S_EXEC_I;
               OP_BEQ:       state_next = S_BRANCH;
               OP_J:         state_next = S_JUMP;
               default:      state_next = S_FAULT;
            endcase
         end
         S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_next = mem_ready ? S_LW_WB : S_MEM_RD;
         S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
         S_LW_WB:    state_next = S_FETCH;
         S_EXEC_R:   state_next = S_R_WB;
         S_R_WB:     state_next = S_FETCH;
         S_EXEC_I:   state_next = S_I_WB;
         S_I_WB:     state_next = S_FETCH;
         S_BRANCH:   state_next = S_FETCH;
         S_JUMP:     state_next = S_FETCH;
         S_FAULT:    state_next = S_FAULT;
         default:    state_next = S_RESET;
      endcase
   end

   // Retired-instruction counter, wraps naturally at 2^RETIRE_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
      end else if (ctrl.instr_done) begin
         retired <= retired + RETIRE_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a 4-bit retire counter so the
// wrap is reachable. Inputs change 1 ns after each rising edge and all
// outputs are compared 1 ns later, well clear of the next edge.
module tb_multicycle_ctrl;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       alu_zero;
   logic       mem_ready;
   logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
   logic       alu_src_a, reg_dst, instr_done, fault;
   logic [1:0] alu_src_b, wb_sel, pc_src;
   logic [3:0] alu_op;
   logic [3:0] retired;

   int testCount = 0;
   int failCount = 0;

   multicycle_ctrl #(.RETIRE_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .alu_zero   (alu_zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_dst    (reg_dst),
      .wb_sel     (wb_sel),
      .pc_src     (pc_src),
      .instr_done (instr_done),
      .retired    (retired),
      .fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output bundle order: mem_req mem_we iord ir_write pc_write reg_write
   // alu_src_a alu_src_b[2] alu_op[4] reg_dst wb_sel[2] pc_src[2] instr_done fault
   logic [19:0] obs;
   assign obs = {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, alu_op, reg_dst, wb_sel, pc_src,
                 instr_done, fault};

   localparam logic [19:0] E_ZERO  = 20'h0;
   localparam logic [19:0] E_F_RDY = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b01,4'b0000,1'b0,2'b00,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_F_WT  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,4'b0000,1'b0,2'b00,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,4'b0000,1'b0,2'b00,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_MADDR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,4'b0000,1'b0,2'b00,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_MRD   = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,2'b00,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_LWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,4'b0000,1'b0,2'b01,2'b00,1'b1,1'b0};
   localparam logic [19:0] E_MWR_W = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,2'b00,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_MWR_R = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,2'b00,2'b00,1'b1,1'b0};
   localparam logic [19:0] E_EXR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,4'b0010,1'b0,2'b00,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_RWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,4'b0000,1'b1,2'b00,2'b00,1'b1,1'b0};
   localparam logic [19:0] E_IWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,4'b0000,1'b0,2'b00,2'b00,1'b1,1'b0};
   localparam logic [19:0] E_BR_T  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,4'b0001,1'b0,2'b00,2'b01,1'b1,1'b0};
   localparam logic [19:0] E_BR_N  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,4'b0001,1'b0,2'b00,2'b01,1'b1,1'b0};
   localparam logic [19:0] E_JMP   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,4'b0000,1'b0,2'b00,2'b10,1'b1,1'b0};
   localparam logic [19:0] E_FLT   = 20'h00001;

   // Advance one cycle and present the inputs for the new state's cycle
   task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic zero);
      @(posedge clk);
      #1;
      opcode    = op;
      mem_ready = rdy;
      alu_zero  = zero;
      #1;
   endtask

   // One comparison: count it, and count/report it when it disagrees
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'h00;
      alu_zero  = 1'b0;
      mem_ready = 1'b1;

      // Reset held for three cycles: everything quiet
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'h00, 1'b1, 1'b0);
         checkOutput("reset_outs", 32'(obs), 32'(E_ZERO));
         checkOutput("reset_retired", 32'(retired), 32'd0);
      end

      // Release: one RESET cycle with all outputs 0, then FETCH
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      opcode = 6'h23;
      #1;
      checkOutput("reset_cycle", 32'(obs), 32'(E_ZERO));

      // LW, memory always ready: 5 cycles
      applyStimulus(6'h23, 1'b1, 1'b0);
      checkOutput("lw_fetch", 32'(obs), 32'(E_F_RDY));
      applyStimulus(6'h23, 1'b1, 1'b0);
      checkOutput("lw_decode", 32'(obs), 32'(E_DEC));
      applyStimulus(6'h23, 1'b1, 1'b0);
      checkOutput("lw_memaddr", 32'(obs), 32'(E_MADDR));
      applyStimulus(6'h23, 1'b1, 1'b0);
      checkOutput("lw_memrd", 32'(obs), 32'(E_MRD));
      applyStimulus(6'h23, 1'b1, 1'b0);
      checkOutput("lw_wb", 32'(obs), 32'(E_LWB));
      checkOutput("lw_retired_before", 32'(retired), 32'd0);

      // SW with three wait cycles in MEM_WR
      applyStimulus(6'h2B, 1'b1, 1'b0);
      checkOutput("sw_fetch", 32'(obs), 32'(E_F_RDY));
      checkOutput("lw_retired_after", 32'(retired), 32'd1);
      applyStimulus(6'h2B, 1'b1, 1'b0);
      checkOutput("sw_decode", 32'(obs), 32'(E_DEC));
      applyStimulus(6'h2B, 1'b1, 1'b0);
      checkOutput("sw_memaddr", 32'(obs), 32'(E_MADDR));
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'h2B, 1'b0, 1'b0);
         checkOutput("sw_wait", 32'(obs), 32'(E_MWR_W));
         checkOutput("sw_wait_retired", 32'(retired), 32'd1);
      end
      applyStimulus(6'h2B, 1'b1, 1'b0);
      checkOutput("sw_ready", 32'(obs), 32'(E_MWR_R));

      // BEQ taken
      applyStimulus(6'h04, 1'b1, 1'b1);
      checkOutput("beqt_fetch", 32'(obs), 32'(E_F_RDY));
      checkOutput("sw_retired", 32'(retired), 32'd2);
      applyStimulus(6'h04, 1'b1, 1'b1);
      checkOutput("beqt_decode", 32'(obs), 32'(E_DEC));
      applyStimulus(6'h04, 1'b1, 1'b1);
      checkOutput("beqt_branch", 32'(obs), 32'(E_BR_T));

      // BEQ not taken
      applyStimulus(6'h04, 1'b1, 1'b0);
      checkOutput("beqn_fetch", 32'(obs), 32'(E_F_RDY));
      checkOutput("beqt_retired", 32'(retired), 32'd3);
      applyStimulus(6'h04, 1'b1, 1'b0);
      checkOutput("beqn_decode", 32'(obs), 32'(E_DEC));
      applyStimulus(6'h04, 1'b1, 1'b0);
      checkOutput("beqn_branch", 32'(obs), 32'(E_BR_N));

      // R-type
      applyStimulus(6'h00, 1'b1, 1'b0);
      checkOutput("rtype_fetch", 32'(obs), 32'(E_F_RDY));
      checkOutput("beqn_retired", 32'(retired), 32'd4);
      applyStimulus(6'h00, 1'b1, 1'b0);
      checkOutput("rtype_decode", 32'(obs), 32'(E_DEC));
      applyStimulus(6'h00, 1'b1, 1'b0);
      checkOutput("rtype_exec", 32'(obs), 32'(E_EXR));
      applyStimulus(6'h00, 1'b1, 1'b0);
      checkOutput("rtype_wb", 32'(obs), 32'(E_RWB));

      // ADDI
      applyStimulus(6'h08, 1'b1, 1'b0);
      checkOutput("addi_fetch", 32'(obs), 32'(E_F_RDY));
      checkOutput("rtype_retired", 32'(retired), 32'd5);
      applyStimulus(6'h08, 1'b1, 1'b0);
      checkOutput("addi_decode", 32'(obs), 32'(E_DEC));
      applyStimulus(6'h08, 1'b1, 1'b0);
      checkOutput("addi_exec", 32'(obs), 32'(E_MADDR));
      applyStimulus(6'h08, 1'b1, 1'b0);
      checkOutput("addi_wb", 32'(obs), 32'(E_IWB));

      // Illegal opcode parks in FAULT; mem_ready is ignored there
      applyStimulus(6'h3F, 1'b1, 1'b0);
      checkOutput("ill_fetch", 32'(obs), 32'(E_F_RDY));
      checkOutput("addi_retired", 32'(retired), 32'd6);
      applyStimulus(6'h3F, 1'b1, 1'b0);
      checkOutput("ill_decode", 32'(obs), 32'(E_DEC));
      for (int i = 0; i < 20; i++) begin
         applyStimulus(6'h3F, i[0], 1'b1);
         checkOutput("fault_outs", 32'(obs), 32'(E_FLT));
         checkOutput("fault_retired", 32'(retired), 32'd6);
      end

      // Reset pulse clears fault and the counter
      @(posedge clk);
      #1;
      rst_n  = 1'b0;
      opcode = 6'h02;
      #1;
      checkOutput("fault_clear_outs", 32'(obs), 32'(E_ZERO));
      checkOutput("fault_clear_retired", 32'(retired), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("reset_cycle2", 32'(obs), 32'(E_ZERO));

      // 17 jumps on a 4-bit counter wrap to 1; first fetch waits once
      applyStimulus(6'h02, 1'b0, 1'b0);
      checkOutput("j_fetch_wait", 32'(obs), 32'(E_F_WT));
      for (int i = 0; i < 17; i++) begin
         applyStimulus(6'h02, 1'b1, 1'b0);
         checkOutput("j_fetch", 32'(obs), 32'(E_F_RDY));
         applyStimulus(6'h02, 1'b1, 1'b0);
         checkOutput("j_decode", 32'(obs), 32'(E_DEC));
         applyStimulus(6'h02, 1'b1, 1'b0);
         checkOutput("j_jump", 32'(obs), 32'(E_JMP));
      end

      // LW whose read stalls, then reset asserted mid-wait
      applyStimulus(6'h23, 1'b1, 1'b0);
      checkOutput("j_wrap_retired", 32'(retired), 32'd1);
      checkOutput("lw2_fetch", 32'(obs), 32'(E_F_RDY));
      applyStimulus(6'h23, 1'b1, 1'b0);
      checkOutput("lw2_decode", 32'(obs), 32'(E_DEC));
      applyStimulus(6'h23, 1'b0, 1'b0);
      checkOutput("lw2_memaddr", 32'(obs), 32'(E_MADDR));
      applyStimulus(6'h23, 1'b0, 1'b0);
      checkOutput("lw2_wait1", 32'(obs), 32'(E_MRD));
      applyStimulus(6'h23, 1'b0, 1'b0);
      checkOutput("lw2_wait2", 32'(obs), 32'(E_MRD));
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midwait_reset_outs", 32'(obs), 32'(E_ZERO));
      checkOutput("midwait_reset_retired", 32'(retired), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
